// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR access sequencer and its last-write cache.
// No logic here; state encoding and index width live in one place.
package gpr_pkg;

    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] ZERO_IDX = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_GAP,
        ST_RD_B,
        ST_WR
    } gpr_state_e;

endpackage

// File: rtl/gpr_access_seq_fwd.sv
// gpr_fwd_cache: last-write cache (index, data, valid) with two combinational lookup ports.
// Loads in the same cycle a nonzero write is accepted; hits are visible the following cycle.
module gpr_fwd_cache
    import gpr_pkg::*;
#(
    parameter int REG_SZ = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_i,
    input  logic [IDX_W-1:0]  ld_idx_i,
    input  logic [REG_SZ-1:0] ld_dat_i,
    input  logic [IDX_W-1:0]  a_idx_i,
    input  logic [IDX_W-1:0]  b_idx_i,
    output logic              a_hit_o,
    output logic [REG_SZ-1:0] a_dat_o,
    output logic              b_hit_o,
    output logic [REG_SZ-1:0] b_dat_o
);

    logic              vld_q;
    logic [IDX_W-1:0]  idx_q;
    logic [REG_SZ-1:0] dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            idx_q <= ZERO_IDX;
            dat_q <= '0;
        end else if (ld_i) begin
            vld_q <= 1'b1;
            idx_q <= ld_idx_i;
            dat_q <= ld_dat_i;
        end
    end

    // Index 0 is never loaded, but guard anyway so r0 can never alias a cached value.
    assign a_hit_o = vld_q && (a_idx_i == idx_q) && (a_idx_i != ZERO_IDX);
    assign b_hit_o = vld_q && (b_idx_i == idx_q) && (b_idx_i != ZERO_IDX);
    assign a_dat_o = dat_q;
    assign b_dat_o = dat_q;

endmodule

// File: rtl/gpr_access_seq.sv
// GPR access sequencer: turns operand fetches / writebacks into one-cycle re/we strobes; read 0-3 cycles, write 0-1.
// Accepts only when idle (writeback wins); requesters hold level requests until ack. GPR_FWD_EN adds a last-write cache.
module gpr_access_seq
    import gpr_pkg::*;
#(
    parameter int REG_SZ = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_i,
    input  logic [IDX_W-1:0]  rs_idx_i,
    input  logic [IDX_W-1:0]  rt_idx_i,
    output logic              rd_ack_o,
    output logic [REG_SZ-1:0] rs_val_o,
    output logic [REG_SZ-1:0] rt_val_o,
    input  logic              wb_req_i,
    input  logic [IDX_W-1:0]  wb_idx_i,
    input  logic [REG_SZ-1:0] wb_data_i,
    output logic              wb_ack_o,
    output logic              busy_o,
    output logic [IDX_W-1:0]  rf_r_idx_o,
    output logic              rf_re_o,
    output logic [IDX_W-1:0]  rf_w_idx_o,
    output logic              rf_we_o,
    output logic [REG_SZ-1:0] rf_din_o,
    input  logic [REG_SZ-1:0] rf_dout_i
);

    gpr_state_e        state_q;
    logic              busy_q;
    logic              rd_ack_q;
    logic              wb_ack_q;
    logic [REG_SZ-1:0] rs_val_q;
    logic [REG_SZ-1:0] rt_val_q;
    logic [IDX_W-1:0]  rf_r_idx_q;
    logic              rf_re_q;
    logic [IDX_W-1:0]  rf_w_idx_q;
    logic              rf_we_q;
    logic [REG_SZ-1:0] rf_din_q;
    logic [IDX_W-1:0]  rt_idx_q;
    logic              rt_fast_q;
    logic [REG_SZ-1:0] rt_fast_val_q;

    logic              rs_hit;
    logic              rt_hit;
    logic [REG_SZ-1:0] rs_hit_dat;
    logic [REG_SZ-1:0] rt_hit_dat;
    logic              rs_fast;
    logic              rt_fast;
    logic [REG_SZ-1:0] rs_fast_val;
    logic [REG_SZ-1:0] rt_fast_val;

`ifdef GPR_FWD_EN
    logic wr_load;
    assign wr_load = (state_q == ST_IDLE) && wb_req_i && (wb_idx_i != ZERO_IDX);

    gpr_fwd_cache #(
        .REG_SZ (REG_SZ)
    ) u_fwd_cache (
        .clk      (clk),
        .rst      (rst),
        .ld_i     (wr_load),
        .ld_idx_i (wb_idx_i),
        .ld_dat_i (wb_data_i),
        .a_idx_i  (rs_idx_i),
        .b_idx_i  (rt_idx_i),
        .a_hit_o  (rs_hit),
        .a_dat_o  (rs_hit_dat),
        .b_hit_o  (rt_hit),
        .b_dat_o  (rt_hit_dat)
    );
`else
    assign rs_hit     = 1'b0;
    assign rt_hit     = 1'b0;
    assign rs_hit_dat = '0;
    assign rt_hit_dat = '0;
`endif

    // "Fast" operands (r0 or cache hit) need no strobe and resolve at the accept edge.
    assign rs_fast     = (rs_idx_i == ZERO_IDX) || rs_hit;
    assign rt_fast     = (rt_idx_i == ZERO_IDX) || rt_hit;
    assign rs_fast_val = rs_hit ? rs_hit_dat : '0;
    assign rt_fast_val = rt_hit ? rt_hit_dat : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            rd_ack_q      <= 1'b0;
            wb_ack_q      <= 1'b0;
            rs_val_q      <= '0;
            rt_val_q      <= '0;
            rf_r_idx_q    <= ZERO_IDX;
            rf_re_q       <= 1'b0;
            rf_w_idx_q    <= ZERO_IDX;
            rf_we_q       <= 1'b0;
            rf_din_q      <= '0;
            rt_idx_q      <= ZERO_IDX;
            rt_fast_q     <= 1'b0;
            rt_fast_val_q <= '0;
        end else begin
            rd_ack_q <= 1'b0;
            wb_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wb_req_i) begin
                        if (wb_idx_i != ZERO_IDX) begin
                            rf_w_idx_q <= wb_idx_i;
                            rf_din_q   <= wb_data_i;
                            rf_we_q    <= 1'b1;
                            state_q    <= ST_WR;
                            busy_q     <= 1'b1;
                        end else begin
                            wb_ack_q <= 1'b1;
                        end
                    end else if (rd_req_i) begin
                        rt_idx_q      <= rt_idx_i;
                        rt_fast_q     <= rt_fast;
                        rt_fast_val_q <= rt_fast_val;
                        if (!rs_fast) begin
                            rf_r_idx_q <= rs_idx_i;
                            rf_re_q    <= 1'b1;
                            state_q    <= ST_RD_A;
                            busy_q     <= 1'b1;
                        end else begin
                            rs_val_q <= rs_fast_val;
                            if (!rt_fast) begin
                                rf_r_idx_q <= rt_idx_i;
                                rf_re_q    <= 1'b1;
                                state_q    <= ST_RD_B;
                                busy_q     <= 1'b1;
                            end else begin
                                rt_val_q <= rt_fast_val;
                                rd_ack_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD_A: begin
                    rs_val_q <= rf_dout_i;
                    rf_re_q  <= 1'b0;
                    if (rt_fast_q) begin
                        rt_val_q <= rt_fast_val_q;
                        rd_ack_q <= 1'b1;
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    rf_r_idx_q <= rt_idx_q;
                    rf_re_q    <= 1'b1;
                    state_q    <= ST_RD_B;
                end
                ST_RD_B: begin
                    rt_val_q <= rf_dout_i;
                    rf_re_q  <= 1'b0;
                    rd_ack_q <= 1'b1;
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
                ST_WR: begin
                    rf_we_q  <= 1'b0;
                    wb_ack_q <= 1'b1;
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    rf_re_q <= 1'b0;
                    rf_we_q <= 1'b0;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_ack_o   = rd_ack_q;
    assign rs_val_o   = rs_val_q;
    assign rt_val_o   = rt_val_q;
    assign wb_ack_o   = wb_ack_q;
    assign busy_o     = busy_q;
    assign rf_r_idx_o = rf_r_idx_q;
    assign rf_re_o    = rf_re_q;
    assign rf_w_idx_o = rf_w_idx_q;
    assign rf_we_o    = rf_we_q;
    assign rf_din_o   = rf_din_q;

endmodule

// File: tb/tb_gpr_access_seq.sv
// Bench for gpr_access_seq: directed vector table, hand-written corner sequences, then random traffic
// checked against an array-based register-file/cache reference model. Honours GPR_FWD_EN if defined.
module tb_gpr_access_seq;

`ifdef GPR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [4:0]  rs_idx, rt_idx;
    logic        rd_ack;
    logic [31:0] rs_val, rt_val;
    logic        wb_req;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        wb_ack;
    logic        busy;
    logic [4:0]  rf_r_idx, rf_w_idx;
    logic        rf_re, rf_we;
    logic [31:0] rf_din, rf_dout;

    always #5 clk = ~clk;

    gpr_access_seq #(.REG_SZ(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req_i   (rd_req),
        .rs_idx_i   (rs_idx),
        .rt_idx_i   (rt_idx),
        .rd_ack_o   (rd_ack),
        .rs_val_o   (rs_val),
        .rt_val_o   (rt_val),
        .wb_req_i   (wb_req),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .wb_ack_o   (wb_ack),
        .busy_o     (busy),
        .rf_r_idx_o (rf_r_idx),
        .rf_re_o    (rf_re),
        .rf_w_idx_o (rf_w_idx),
        .rf_we_o    (rf_we),
        .rf_din_o   (rf_din),
        .rf_dout_i  (rf_dout)
    );

    // Edge-triggered register file; sampled on the falling clock edge so index and strobe are settled.
    logic [31:0] rf_mem [32];
    logic        re_prev = 1'b0, we_prev = 1'b0;
    int          re_cnt = 0, we_cnt = 0, overlap_viol = 0, spacing_viol = 0, zero_viol = 0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000_0000 + 32'(i);
            rf_mem[3] <= 32'h11;
            rf_mem[5] <= 32'h55;
            rf_mem[7] <= 32'h22;
        end
        if (rf_re && rf_we) overlap_viol++;
        if (rf_re && re_prev) spacing_viol++;
        if (rf_we && we_prev) spacing_viol++;
        if (rf_re && !re_prev) begin
            re_cnt++;
            if (rf_r_idx == 5'd0) zero_viol++;
            rf_dout <= rf_mem[rf_r_idx];
        end
        if (rf_we && !we_prev) begin
            we_cnt++;
            if (rf_w_idx == 5'd0) zero_viol++;
            rf_mem[rf_w_idx] <= rf_din;
        end
        re_prev <= rf_re;
        we_prev <= rf_we;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: architectural register contents plus the last-write cache.
    logic [31:0] ref_rf [32];
    logic        c_vld;
    logic [4:0]  c_idx;
    logic [31:0] c_dat;

    function automatic bit m_fast(input logic [4:0] i);
        return (i == 5'd0) || (FWD && c_vld && c_idx == i);
    endfunction

    function automatic logic [31:0] m_val(input logic [4:0] i);
        if (i == 5'd0) return 32'h0;
        if (FWD && c_vld && c_idx == i) return c_dat;
        return ref_rf[i];
    endfunction

    task automatic model_read(input logic [4:0] rs, input logic [4:0] rt, output int lat,
                              output int pulses, output logic [31:0] vrs, output logic [31:0] vrt);
        int n;
        n = (m_fast(rs) ? 0 : 1) + (m_fast(rt) ? 0 : 1);
        pulses = n;
        lat = (n == 2) ? 3 : n;
        vrs = m_val(rs);
        vrt = m_val(rt);
    endtask

    task automatic model_write(input logic [4:0] idx, input logic [31:0] d);
        if (idx != 5'd0) begin
            ref_rf[idx] = d;
            c_vld = 1'b1;
            c_idx = idx;
            c_dat = d;
        end
    endtask

    task automatic run_read(input logic [4:0] rs, input logic [4:0] rt, output int lat, output int pulses);
        int re0;
        re0 = re_cnt;
        @(negedge clk);
        rd_req = 1'b1;
        rs_idx = rs;
        rt_idx = rt;
        @(posedge clk);
        lat = 99;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rd_req = 1'b0;
            if (rd_ack) begin
                lat = k;
                break;
            end
        end
        pulses = re_cnt - re0;
        if (lat != 99) begin
            @(negedge clk);
            chk("rd_ack_one_cycle", rd_ack, 1'b0);
        end
    endtask

    task automatic run_write(input logic [4:0] idx, input logic [31:0] d, output int lat, output int pulses);
        int we0;
        we0 = we_cnt;
        @(negedge clk);
        wb_req  = 1'b1;
        wb_idx  = idx;
        wb_data = d;
        @(posedge clk);
        lat = 99;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            wb_req = 1'b0;
            if (wb_ack) begin
                lat = k;
                break;
            end
        end
        pulses = we_cnt - we0;
        if (lat != 99) begin
            @(negedge clk);
            chk("wb_ack_one_cycle", wb_ack, 1'b0);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] d;
        int          lat;
        logic [31:0] ers;
        logic [31:0] ert;
        int          pulses;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          lat, pulses, elat, epulses, wk, rk, acks, re0;
        logic [31:0] vrs, vrt;
        logic [4:0]  a, b;
        logic [31:0] d;

        rst = 1'b1;
        rd_req = 1'b0; rs_idx = '0; rt_idx = '0;
        wb_req = 1'b0; wb_idx = '0; wb_data = '0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h1000_0000 + 32'(i);
        ref_rf[3] = 32'h11;
        ref_rf[5] = 32'h55;
        ref_rf[7] = 32'h22;
        c_vld = 1'b0; c_idx = '0; c_dat = '0;

        vecs.push_back('{1'b0, 5'd3,  5'd7, 32'h0,      3, 32'h11,        32'h22, 2});
        vecs.push_back('{1'b0, 5'd0,  5'd5, 32'h0,      1, 32'h0,         32'h55, 1});
        vecs.push_back('{1'b1, 5'd0,  5'd0, 32'hFFFF,   0, 32'h0,         32'h0,  0});
        vecs.push_back('{1'b0, 5'd0,  5'd0, 32'h0,      0, 32'h0,         32'h0,  0});
        vecs.push_back('{1'b0, 5'd7,  5'd0, 32'h0,      1, 32'h22,        32'h0,  1});
        vecs.push_back('{1'b1, 5'd12, 5'd0, 32'hDEAD,   1, 32'h0,         32'h0,  1});
        vecs.push_back('{1'b0, 5'd3,  5'd12, 32'h0, FWD ? 1 : 3, 32'h11, 32'hDEAD, FWD ? 1 : 2});
        vecs.push_back('{1'b0, 5'd31, 5'd7, 32'h0,      3, 32'h1000_001F, 32'h22, 2});
        vecs.push_back('{1'b1, 5'd9,  5'd0, 32'hABCD,   1, 32'h0,         32'h0,  1});
        vecs.push_back('{1'b0, 5'd9,  5'd9, 32'h0, FWD ? 0 : 3, 32'hABCD, 32'hABCD, FWD ? 0 : 2});

        @(negedge clk);
        chk("reset_rd_ack", rd_ack, 1'b0);
        chk("reset_wb_ack", wb_ack, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_strobes", {rf_re, rf_we}, 2'b00);
        chk("reset_vals", {rs_val, rt_val}, 64'h0);
        chk("reset_rf_outs", {rf_r_idx, rf_w_idx, rf_din}, 42'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted while the rs strobe is high.
        @(negedge clk);
        rd_req = 1'b1; rs_idx = 5'd3; rt_idx = 5'd7;
        @(posedge clk);
        #1;
        chk("mid_rst_re_before", rf_re, 1'b1);
        chk("mid_rst_busy_before", busy, 1'b1);
        rd_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_re", rf_re, 1'b0);
        chk("mid_rst_ack", rd_ack, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        re0 = re_cnt;
        repeat (6) begin
            @(negedge clk);
            if (rd_ack) acks++;
        end
        chk("mid_rst_no_ack_after", acks, 0);
        chk("mid_rst_no_strobe_after", re_cnt - re0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                run_write(vecs[i].a, vecs[i].d, lat, pulses);
                chk($sformatf("vec%0d_wr_lat", i), lat, vecs[i].lat);
                chk($sformatf("vec%0d_we_pulses", i), pulses, vecs[i].pulses);
                if (vecs[i].a != 5'd0) chk($sformatf("vec%0d_rf_content", i), rf_mem[vecs[i].a], vecs[i].d);
                model_write(vecs[i].a, vecs[i].d);
            end else begin
                run_read(vecs[i].a, vecs[i].b, lat, pulses);
                chk($sformatf("vec%0d_rd_lat", i), lat, vecs[i].lat);
                chk($sformatf("vec%0d_re_pulses", i), pulses, vecs[i].pulses);
                chk($sformatf("vec%0d_rs_val", i), rs_val, vecs[i].ers);
                chk($sformatf("vec%0d_rt_val", i), rt_val, vecs[i].ert);
            end
        end

        // Simultaneous writeback and fetch: write wins, read accepted one cycle after wb_ack.
        @(negedge clk);
        wb_req = 1'b1; wb_idx = 5'd4; wb_data = 32'h1234;
        rd_req = 1'b1; rs_idx = 5'd4; rt_idx = 5'd4;
        @(posedge clk);
        wk = 99;
        rk = 99;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wb_ack && wk == 99) begin
                wk = k;
                wb_req = 1'b0;
            end
            if (rd_ack) begin
                rk = k;
                rd_req = 1'b0;
                break;
            end
        end
        wb_req = 1'b0;
        rd_req = 1'b0;
        model_write(5'd4, 32'h1234);
        model_read(5'd4, 5'd4, elat, epulses, vrs, vrt);
        chk("both_req_wb_ack_cycle", wk, 1);
        chk("both_req_rd_ack_cycle", rk, 2 + elat);
        chk("both_req_rs_val", rs_val, 32'h1234);
        chk("both_req_rt_val", rt_val, 32'h1234);
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 10));
            b = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 10));
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom;
                run_write(a, d, lat, pulses);
                chk("rnd_wr_lat", lat, (a != 5'd0) ? 1 : 0);
                chk("rnd_we_pulses", pulses, (a != 5'd0) ? 1 : 0);
                model_write(a, d);
            end else begin
                model_read(a, b, elat, epulses, vrs, vrt);
                run_read(a, b, lat, pulses);
                chk("rnd_rd_lat", lat, elat);
                chk("rnd_re_pulses", pulses, epulses);
                chk("rnd_rs_val", rs_val, vrs);
                chk("rnd_rt_val", rt_val, vrt);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk("strobe_overlap", overlap_viol, 0);
        chk("strobe_spacing", spacing_viol, 0);
        chk("strobe_on_r0", zero_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
